// File: rtl/rf_wr_arbiter_pkg.sv
// Core register-file constants shared by the writeback path: widths, register count, zero register, starvation limit.
package rf_wr_arbiter_pkg;

    localparam int unsigned RF_XLEN         = 32;
    localparam int unsigned RF_NREGS        = 32;
    localparam int unsigned RF_ADDR_W       = $clog2(RF_NREGS);
    localparam int unsigned RF_ZERO_REG     = 0;
    localparam int unsigned RF_STARVE_LIMIT = 8;

    localparam int unsigned WAIT_W  = 8;
    localparam int unsigned STALL_W = 16;

    // Circular successor within 0..n-1.
    function automatic int unsigned rr_next(input int unsigned k, input int unsigned n);
        return (k + 1 >= n) ? 0 : k + 1;
    endfunction

endpackage

// File: rtl/rf_wr_arbiter_rr_pick.sv
// Circular first-one finder: one-hot of the first set bit of req_i at or after ptr_i, wrapping.
// Purely combinational; an all-zero request vector yields an all-zero result.
module rr_pick #(
    parameter int unsigned N     = 2,
    parameter int unsigned PTR_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        // Upper segment [ptr..N-1] first, then the wrapped segment [0..ptr-1].
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i] && (i >= int'(ptr_i))) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i] && (i < int'(ptr_i))) begin
                gnt_o[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: requester 0 fixed priority, others round-robin with starvation override.
// Grant is combinational (0 cycles); winning write is registered onto the port 1 cycle later; losers hold.
module rf_wr_arbiter
    import rf_wr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned ADDR_W       = RF_ADDR_W,
    parameter int unsigned DATA_W       = RF_XLEN,
    parameter int unsigned STARVE_LIMIT = RF_STARVE_LIMIT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_vld,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_gnt,
    output logic                        rf_wr_en,
    output logic [ADDR_W-1:0]           rf_wr_addr,
    output logic [DATA_W-1:0]           rf_wr_data,
    output logic [STALL_W-1:0]          stall_cnt
);

    localparam int unsigned NR    = NUM_REQ - 1;
    localparam int unsigned PTR_W = (NR > 1) ? $clog2(NR) : 1;

    // Pointer is stored as an offset into requesters 1..NUM_REQ-1 (0 means requester 1).
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WAIT_W-1:0]  wait_cnt_q [NR];
    logic [WAIT_W-1:0]  wait_cnt_d [NR];
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;

    logic [NR-1:0]      vld_hi, starved, pick_starve, pick_norm;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               xfer, denied;

    assign vld_hi = req_vld[NUM_REQ-1:1];

    always_comb begin
        starved = '0;
        for (int k = 0; k < NR; k++) begin
            starved[k] = vld_hi[k] && (wait_cnt_q[k] >= WAIT_W'(STARVE_LIMIT));
        end
    end

    rr_pick #(.N(NR), .PTR_W(PTR_W)) u_pick_starve (
        .req_i (starved),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_starve)
    );

    rr_pick #(.N(NR), .PTR_W(PTR_W)) u_pick_norm (
        .req_i (vld_hi),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_norm)
    );

    always_comb begin
        req_gnt = '0;
        if (!rst) begin
            if (|starved) begin
                req_gnt = {pick_starve, 1'b0};
            end else if (req_vld[0]) begin
                req_gnt[0] = 1'b1;
            end else begin
                req_gnt = {pick_norm, 1'b0};
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_gnt[i]) begin
                sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
                sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign xfer   = |req_gnt;
    assign denied = |(req_vld & ~req_gnt);

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        stall_cnt_d = stall_cnt_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        for (int k = 0; k < NR; k++) begin
            wait_cnt_d[k] = wait_cnt_q[k];
            if (req_gnt[k+1]) begin
                rr_ptr_d = PTR_W'(rr_next(unsigned'(k), NR));
            end
            if (!vld_hi[k] || req_gnt[k+1]) begin
                wait_cnt_d[k] = '0;
            end else if (wait_cnt_q[k] != '1) begin
                wait_cnt_d[k] = wait_cnt_q[k] + WAIT_W'(1);
            end
        end
        if (denied && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
        // A write to the zero register consumes its grant but never strobes the port.
        if (xfer) begin
            wr_en_d   = (sel_addr != ADDR_W'(RF_ZERO_REG));
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            stall_cnt_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            for (int k = 0; k < NR; k++) begin
                wait_cnt_q[k] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            stall_cnt_q <= stall_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            for (int k = 0; k < NR; k++) begin
                wait_cnt_q[k] <= wait_cnt_d[k];
            end
        end
    end

    assign rf_wr_en   = wr_en_q;
    assign rf_wr_addr = wr_addr_q;
    assign rf_wr_data = wr_data_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter: grants checked in-cycle, expected port writes queued and compared a cycle later.
module tb_rf_wr_arbiter;

    typedef struct packed {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_vld;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_gnt;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;
    logic [15:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    logic [4:0]  a [3];
    logic [31:0] d [3];
    logic [4:0]  last_addr;
    logic [31:0] last_data;
    wr_t         exp_q [$];
    logic [31:0] rf_m [32] = '{default: '0};

    rf_wr_arbiter #(
        .NUM_REQ(3), .ADDR_W(5), .DATA_W(32), .STARVE_LIMIT(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_vld    (req_vld),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_gnt    (req_gnt),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    // Register-file model fed by the write port, with read-after-write bypass of the in-flight write.
    always @(posedge clk) begin
        if (rf_wr_en) rf_m[rf_wr_addr] <= rf_wr_data;
    end

    function automatic logic [31:0] rd(input logic [4:0] r);
        if (rf_wr_en && (rf_wr_addr == r)) return rf_wr_data;
        return rf_m[r];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bus();
        req_addr = {a[2], a[1], a[0]};
        req_data = {d[2], d[1], d[0]};
    endtask

    task automatic pop_check(input string tag);
        wr_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s/queue observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "/en"},   64'(rf_wr_en),   64'(e.en));
            chk({tag, "/addr"}, 64'(rf_wr_addr), 64'(e.addr));
            chk({tag, "/data"}, 64'(rf_wr_data), 64'(e.data));
        end
    endtask

    // One cycle: drive at negedge, check grant, queue the expected port state, check it after the edge.
    task automatic step(input logic [2:0] vld, input logic [2:0] gexp, input string tag);
        wr_t e;
        @(negedge clk);
        rst     = 1'b0;
        req_vld = vld;
        drive_bus();
        #1;
        chk({tag, "/gnt"}, 64'(req_gnt), 64'(gexp));
        e.en   = 1'b0;
        e.addr = last_addr;
        e.data = last_data;
        for (int i = 0; i < 3; i++) begin
            if (gexp[i]) begin
                e.en   = (a[i] != 5'd0);
                e.addr = a[i];
                e.data = d[i];
            end
        end
        last_addr = e.addr;
        last_data = e.data;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_vld   = 3'b111;
        last_addr = '0;
        last_data = '0;
        a[0] = 5'd1; d[0] = 32'h1111_1111;
        a[1] = 5'd2; d[1] = 32'h2222_2222;
        a[2] = 5'd3; d[2] = 32'h3333_3333;
        drive_bus();
        repeat (2) @(posedge clk);
        #1;
        chk("rst/gnt",   64'(req_gnt),    64'd0);
        chk("rst/en",    64'(rf_wr_en),   64'd0);
        chk("rst/addr",  64'(rf_wr_addr), 64'd0);
        chk("rst/data",  64'(rf_wr_data), 64'd0);
        chk("rst/stall", 64'(stall_cnt),  64'd0);

        step(3'b111, 3'b001, "prio0");
        step(3'b110, 3'b010, "prio1");
        step(3'b100, 3'b100, "prio2");
        chk("prio/stall", 64'(stall_cnt), 64'd2);

        a[1] = 5'd5; d[1] = 32'hA5A5_0001;
        step(3'b010, 3'b010, "single");
        chk("single/rd_bypass", 64'(rd(5'd5)), 64'hA5A5_0001);
        step(3'b000, 3'b000, "idle0");
        chk("single/rd_commit", 64'(rd(5'd5)), 64'hA5A5_0001);
        chk("single/stall", 64'(stall_cnt), 64'd2);

        a[2] = 5'd0; d[2] = 32'hFFFF_FFFF;
        step(3'b100, 3'b100, "x0");
        chk("x0/rd0", 64'(rd(5'd0)), 64'd0);
        step(3'b000, 3'b000, "idle_x0");
        chk("x0/rd0_after", 64'(rd(5'd0)), 64'd0);

        a[1] = 5'd2; d[1] = 32'h2222_2222;
        a[2] = 5'd3; d[2] = 32'h3333_3333;
        for (int i = 0; i < 6; i++) begin
            step(3'b110, (i % 2 == 0) ? 3'b010 : 3'b100, "rr");
        end
        chk("rr/stall", 64'(stall_cnt), 64'd8);
        step(3'b000, 3'b000, "idle1");

        for (int i = 0; i < 8; i++) begin
            step(3'b011, 3'b001, "starve_wait");
        end
        step(3'b011, 3'b010, "starve_ovr");
        step(3'b011, 3'b001, "starve_after");
        chk("starve/stall", 64'(stall_cnt), 64'd18);
        step(3'b000, 3'b000, "idle2");

        // Leaves the pointer at requester 2, so the post-reset grant shows the pointer was restored.
        step(3'b010, 3'b010, "pre_rst");
        @(negedge clk);
        rst     = 1'b1;
        req_vld = 3'b110;
        #1;
        chk("mid_rst/gnt", 64'(req_gnt), 64'd0);
        @(posedge clk);
        #1;
        chk("mid_rst/en",    64'(rf_wr_en),   64'd0);
        chk("mid_rst/addr",  64'(rf_wr_addr), 64'd0);
        chk("mid_rst/data",  64'(rf_wr_data), 64'd0);
        chk("mid_rst/stall", 64'(stall_cnt),  64'd0);
        last_addr = '0;
        last_data = '0;
        step(3'b110, 3'b010, "post_rst");
        step(3'b100, 3'b100, "post_rst2");
        chk("post_rst/stall", 64'(stall_cnt), 64'd1);
        step(3'b000, 3'b000, "idle3");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
